// File: rtl/spiwb_pkg.sv
// Shared definitions for the SPI-to-wishbone burst bridge.
package spiwb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } state_t;

  // Header bit positions, counted in arrival order (bit 0 is first on the wire)
  localparam int HDR_RW_IDX  = 0;
  localparam int HDR_INC_IDX = 1;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizers for the SPI pins plus sclk and cs edge detection.
module spi_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic pin_cs,
  input  logic pin_sclk,
  input  logic pin_mosi,
  output logic mosi_s,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_fall,
  output logic cs_rise
);

  logic [1:0] cs_ff;
  logic [1:0] sclk_ff;
  logic [1:0] mosi_ff;
  logic       cs_d;
  logic       sclk_d;

  // Synchronizer chains and one-cycle-delayed copies for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_ff   <= '1;
      cs_d    <= 1'b1;
      sclk_ff <= '0;
      sclk_d  <= 1'b0;
      mosi_ff <= '0;
    end else begin
      cs_ff   <= {cs_ff[0], pin_cs};
      cs_d    <= cs_ff[1];
      sclk_ff <= {sclk_ff[0], pin_sclk};
      sclk_d  <= sclk_ff[1];
      mosi_ff <= {mosi_ff[0], pin_mosi};
    end
  end

  // Edge strobes; sclk edges only count while the device is selected
  always_comb begin
    mosi_s    = mosi_ff[1];
    sclk_rise = sclk_ff[1] & ~sclk_d & ~cs_ff[1];
    sclk_fall = ~sclk_ff[1] & sclk_d & ~cs_ff[1];
    cs_fall   = ~cs_ff[1] & cs_d;
    cs_rise   = cs_ff[1] & ~cs_d;
  end

endmodule

// File: rtl/spiwb_burst.sv
// SPI (mode 0) slave to wishbone master bridge with burst read/write frames.
// Frame: RW, INC, ADDR_W address bits, then DATA_W-bit words until cs rises.
// Optional build macro SPIWB_TIMEOUT_EN adds a wishbone stall timeout.
module spiwb_burst
  import spiwb_pkg::*;
#(
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pin_cs,
  input  logic              pin_sclk,
  input  logic              pin_mosi,
  output logic              pin_miso,
  output logic              wb_stb_o,
  output logic              wb_cyc_o,
  output logic              wb_we_o,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [DATA_W-1:0] wb_dat_o,
  input  logic [DATA_W-1:0] wb_dat_i,
  input  logic              wb_ack_i,
  output logic              err_o,
  output logic              busy_o
);

  localparam int HDR_W = 2 + ADDR_W;
  localparam int HCW   = $clog2(HDR_W);
  localparam int WCW   = $clog2(DATA_W);

  logic mosi_s, sclk_rise, sclk_fall, cs_fall, cs_rise;

  spi_sync_edge u_sync (
    .clk       (clk),
    .rst       (rst),
    .pin_cs    (pin_cs),
    .pin_sclk  (pin_sclk),
    .pin_mosi  (pin_mosi),
    .mosi_s    (mosi_s),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .cs_fall   (cs_fall),
    .cs_rise   (cs_rise)
  );

  state_t            state;
  logic [HCW-1:0]    hcnt;
  logic [HDR_W-2:0]  hdr_sh;
  logic              rw, inc;
  logic [ADDR_W-1:0] hdr_addr;
  logic [WCW-1:0]    wcnt;
  logic [DATA_W-2:0] sh_in;
  logic [DATA_W-1:0] sh_out;
  logic [DATA_W-1:0] pbuf;
  logic              pbuf_valid;
  logic              pf_req;
  logic              adr_ld;
  logic              tmo_hit;
  logic              wb_done, wb_free;
  logic [HDR_W-1:0]  hdr_full;
  logic [DATA_W-1:0] word_full;
  logic [DATA_W-1:0] rd_word;

`ifdef SPIWB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;

  // Count cycles the current wishbone strobe has been waiting for ack
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      tmo_cnt <= '0;
    else if (!wb_stb_o || wb_done)
      tmo_cnt <= '0;
    else
      tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign tmo_hit = wb_stb_o && (tmo_cnt == TW'(TIMEOUT - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // Wishbone handshake status and incoming shift words
  always_comb begin
    wb_done   = wb_stb_o & (wb_ack_i | tmo_hit);
    wb_free   = ~wb_stb_o | wb_done;
    hdr_full  = {hdr_sh, mosi_s};
    word_full = {sh_in, mosi_s};
    rd_word   = wb_ack_i ? wb_dat_i : '0;
  end

  assign wb_cyc_o = wb_stb_o;
  assign busy_o   = (state != IDLE) | wb_stb_o;

  // Frame FSM, SPI shifters and wishbone master
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      hcnt       <= '0;
      hdr_sh     <= '0;
      rw         <= 1'b0;
      inc        <= 1'b0;
      hdr_addr   <= '0;
      wcnt       <= '0;
      sh_in      <= '0;
      sh_out     <= '0;
      pbuf       <= '0;
      pbuf_valid <= 1'b0;
      pf_req     <= 1'b0;
      adr_ld     <= 1'b0;
      wb_stb_o   <= 1'b0;
      wb_we_o    <= 1'b0;
      wb_adr_o   <= '0;
      wb_dat_o   <= '0;
      err_o      <= 1'b0;
      pin_miso   <= 1'b0;
    end else begin
      if (wb_done) begin
        wb_stb_o <= 1'b0;
        if (!wb_we_o) begin
          pbuf       <= rd_word;
          pbuf_valid <= 1'b1;
        end
        // A new frame's address waits here if it arrived while a cycle was pending
        if (adr_ld) begin
          wb_adr_o <= hdr_addr;
          adr_ld   <= 1'b0;
        end else if (inc) begin
          wb_adr_o <= wb_adr_o + 1'b1;
        end
        if (tmo_hit && !wb_ack_i)
          err_o <= 1'b1;
      end

      if (pf_req && wb_free) begin
        wb_stb_o <= 1'b1;
        wb_we_o  <= 1'b0;
        pf_req   <= 1'b0;
      end

      case (state)
        IDLE: begin
          pin_miso <= 1'b0;
          if (cs_fall) begin
            state <= HDR;
            hcnt  <= '0;
          end
        end

        HDR: begin
          pin_miso <= 1'b0;
          if (sclk_rise) begin
            hdr_sh <= hdr_full[HDR_W-2:0];
            hcnt   <= hcnt + 1'b1;
            if (hcnt == HCW'(HDR_W - 1)) begin
              state      <= DATA;
              wcnt       <= '0;
              rw         <= hdr_full[HDR_W-1-HDR_RW_IDX];
              inc        <= hdr_full[HDR_W-1-HDR_INC_IDX];
              hdr_addr   <= hdr_full[ADDR_W-1:0];
              pbuf_valid <= 1'b0;
              if (wb_free) begin
                wb_adr_o <= hdr_full[ADDR_W-1:0];
                adr_ld   <= 1'b0;
              end else begin
                adr_ld   <= 1'b1;
              end
              if (!hdr_full[HDR_W-1-HDR_RW_IDX]) begin
                if (wb_free) begin
                  wb_stb_o <= 1'b1;
                  wb_we_o  <= 1'b0;
                end else begin
                  pf_req   <= 1'b1;
                end
              end
            end
          end
        end

        DATA: begin
          if (sclk_rise) begin
            sh_in <= word_full[DATA_W-2:0];
            if (wcnt == WCW'(DATA_W - 1)) begin
              wcnt <= '0;
              if (rw) begin
                if ((&hdr_addr) && mosi_s) begin
                  err_o <= 1'b0;
                end else if (!wb_free) begin
                  err_o <= 1'b1;
                end else begin
                  wb_stb_o <= 1'b1;
                  wb_we_o  <= 1'b1;
                  wb_dat_o <= word_full;
                end
              end
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end

          // MISO changes on the sclk fall so it is stable for the host's rising sample
          if (sclk_fall && !rw) begin
            if (wcnt == '0) begin
              if (pbuf_valid) begin
                sh_out     <= pbuf;
                pin_miso   <= pbuf[DATA_W-1];
                pbuf_valid <= 1'b0;
                if (wb_free) begin
                  wb_stb_o <= 1'b1;
                  wb_we_o  <= 1'b0;
                end else begin
                  pf_req   <= 1'b1;
                end
              end else begin
                sh_out   <= '0;
                pin_miso <= 1'b0;
                err_o    <= 1'b1;
              end
            end else begin
              sh_out   <= sh_out << 1;
              pin_miso <= sh_out[DATA_W-2];
            end
          end
        end

        default: state <= IDLE;
      endcase

      if (cs_rise) begin
        state  <= IDLE;
        pf_req <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spiwb_burst.sv
// Directed bench for spiwb_burst: SPI host driver, wishbone slave model and
// transaction log checked against hand-computed values.
module tb_spiwb_burst;

  localparam int AW = 7;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          pin_cs, pin_sclk, pin_mosi, pin_miso;
  logic          wb_stb_o, wb_cyc_o, wb_we_o, wb_ack_i;
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_o, wb_dat_i;
  logic          err_o, busy_o;

  always #5 clk = ~clk;

  spiwb_burst #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(255)) dut (
    .clk      (clk),
    .rst      (rst),
    .pin_cs   (pin_cs),
    .pin_sclk (pin_sclk),
    .pin_mosi (pin_mosi),
    .pin_miso (pin_miso),
    .wb_stb_o (wb_stb_o),
    .wb_cyc_o (wb_cyc_o),
    .wb_we_o  (wb_we_o),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_dat_i (wb_dat_i),
    .wb_ack_i (wb_ack_i),
    .err_o    (err_o),
    .busy_o   (busy_o)
  );

  // Wishbone slave: acks ack_dly cycles after strobe when enabled
  logic [DW-1:0] rd_value = 32'hCAFEF00D;
  int            ack_dly  = 1;
  logic          ack_en   = 1'b1;
  int            wait_cnt = 0;
  assign wb_dat_i = rd_value;

  always @(posedge clk) begin
    if (rst || !wb_stb_o || wb_ack_i) begin
      wb_ack_i <= 1'b0;
      wait_cnt <= 0;
    end else if (ack_en && wait_cnt >= ack_dly - 1) begin
      wb_ack_i <= 1'b1;
    end else begin
      wait_cnt <= wait_cnt + 1;
    end
  end

  // Transaction log and strobe run-length monitor
  logic          log_we  [64];
  logic [AW-1:0] log_adr [64];
  logic [DW-1:0] log_dat [64];
  int            log_n = 0;
  int            run = 0;
  int            last_run = 0;

  always @(negedge clk) begin
    if (wb_stb_o && wb_ack_i && log_n < 64) begin
      log_we[log_n]  = wb_we_o;
      log_adr[log_n] = wb_adr_o;
      log_dat[log_n] = wb_dat_o;
      log_n++;
    end
    if (wb_stb_o) run++;
    else if (run != 0) begin
      last_run = run;
      run = 0;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int hp = 8;

  task automatic spi_bits(input logic [63:0] val, input int n, output logic [63:0] rx);
    rx = '0;
    for (int i = 0; i < n; i++) begin
      pin_mosi = val[n-1-i];
      repeat (hp) @(negedge clk);
      rx = {rx[62:0], pin_miso};
      pin_sclk = 1'b1;
      repeat (hp) @(negedge clk);
      pin_sclk = 1'b0;
    end
  endtask

  task automatic cs_low();
    @(negedge clk);
    pin_cs = 1'b0;
    repeat (hp) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (hp) @(negedge clk);
    pin_cs = 1'b1;
  endtask

  task automatic send_hdr(input logic rw, input logic inc, input logic [AW-1:0] addr);
    logic [63:0] v, rx;
    v = '0;
    v[AW+1:0] = {rw, inc, addr};
    spi_bits(v, AW + 2, rx);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (!busy_o) break;
    end
    check_eq(tag, busy_o, 1'b0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] rx, rx1, rx2;
    int base;

    rst = 1'b1; pin_cs = 1'b1; pin_sclk = 1'b0; pin_mosi = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_stb", wb_stb_o, 1'b0);
    check_eq("rst_we", wb_we_o, 1'b0);
    check_eq("rst_miso", pin_miso, 1'b0);
    check_eq("rst_err", err_o, 1'b0);
    check_eq("rst_busy", busy_o, 1'b0);
    check_eq("rst_adr_dat", {wb_adr_o, wb_dat_o}, '0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Burst write with auto-increment
    base = log_n;
    cs_low();
    send_hdr(1'b1, 1'b1, 7'h05);
    spi_bits(64'h11223344, 32, rx);
    check_eq("cyc_eq_stb", wb_cyc_o, wb_stb_o);
    spi_bits(64'hAABBCCDD, 32, rx);
    cs_high();
    wait_idle("wr_idle", 200);
    check_eq("wr_cnt", log_n - base, 2);
    check_eq("wr0", {log_we[base], log_adr[base], log_dat[base]}, {1'b1, 7'h05, 32'h11223344});
    check_eq("wr1", {log_we[base+1], log_adr[base+1], log_dat[base+1]}, {1'b1, 7'h06, 32'hAABBCCDD});
    check_eq("wr_err", err_o, 1'b0);

    // Burst read, fixed address
    base = log_n;
    cs_low();
    send_hdr(1'b0, 1'b0, 7'h10);
    spi_bits(64'h0, 32, rx1);
    spi_bits(64'h0, 32, rx2);
    cs_high();
    wait_idle("rd_idle", 200);
    check_eq("rd_word0", rx1, 64'hCAFEF00D);
    check_eq("rd_word1", rx2, 64'hCAFEF00D);
    check_eq("rd_cnt_ge2", (log_n - base) >= 2, 1'b1);
    check_eq("rd0", {log_we[base], log_adr[base]}, {1'b0, 7'h10});
    check_eq("rd1", {log_we[base+1], log_adr[base+1]}, {1'b0, 7'h10});
    check_eq("rd_err", err_o, 1'b0);

    // Slow slave with fast sclk: underrun, then the clear frame
    hp = 2;
    ack_dly = 500;
    cs_low();
    send_hdr(1'b0, 1'b0, 7'h20);
    spi_bits(64'h0, 32, rx);
    cs_high();
    check_eq("ur_word", rx, 64'h0);
    @(negedge clk);
    check_eq("ur_err", err_o, 1'b1);
    wait_idle("ur_idle", 2000);
    hp = 8;
    ack_dly = 1;
    base = log_n;
    cs_low();
    send_hdr(1'b1, 1'b0, 7'h7F);
    spi_bits(64'h1, 32, rx);
    cs_high();
    wait_idle("clr_idle", 200);
    check_eq("clr_err", err_o, 1'b0);
    check_eq("clr_nocyc", log_n - base, 0);

    // Address wrap under auto-increment
    base = log_n;
    cs_low();
    send_hdr(1'b1, 1'b1, 7'h7E);
    spi_bits(64'h01020304, 32, rx);
    spi_bits(64'h05060708, 32, rx);
    spi_bits(64'h090A0B0C, 32, rx);
    cs_high();
    wait_idle("wrap_idle", 200);
    check_eq("wrap_cnt", log_n - base, 3);
    check_eq("wrap0", {log_adr[base], log_dat[base]}, {7'h7E, 32'h01020304});
    check_eq("wrap1", {log_adr[base+1], log_dat[base+1]}, {7'h7F, 32'h05060708});
    check_eq("wrap2", {log_adr[base+2], log_dat[base+2]}, {7'h00, 32'h090A0B0C});

    // Partial word: cs rises after 20 data bits
    base = log_n;
    cs_low();
    send_hdr(1'b1, 1'b0, 7'h31);
    spi_bits(64'hABCDE, 20, rx);
    cs_high();
    repeat (3) @(posedge clk);
    #1;
    check_eq("part_busy", busy_o, 1'b0);
    repeat (10) @(negedge clk);
    check_eq("part_nocyc", log_n - base, 0);

`ifndef SPIWB_TIMEOUT_EN
    // Write overrun: second word arrives while the first is unacked
    base = log_n;
    ack_en = 1'b0;
    cs_low();
    send_hdr(1'b1, 1'b0, 7'h33);
    spi_bits(64'h12345678, 32, rx);
    spi_bits(64'h9ABCDEF0, 32, rx);
    cs_high();
    @(negedge clk);
    check_eq("ovr_err", err_o, 1'b1);
    check_eq("ovr_pending", log_n - base, 0);
    ack_en = 1'b1;
    wait_idle("ovr_idle", 200);
    check_eq("ovr_cnt", log_n - base, 1);
    check_eq("ovr_wr", {log_adr[base], log_dat[base]}, {7'h33, 32'h12345678});
`endif

    // Reset in the middle of a pending cycle
    ack_en = 1'b0;
    cs_low();
    send_hdr(1'b1, 1'b0, 7'h44);
    spi_bits(64'h55AA55AA, 32, rx);
    check_eq("mid_stb_pre", wb_stb_o, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("mid_stb", wb_stb_o, 1'b0);
    check_eq("mid_busy_err", {busy_o, err_o}, 2'b00);
    pin_cs = 1'b1;
    pin_sclk = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    ack_en = 1'b1;
    repeat (4) @(negedge clk);

`ifdef SPIWB_TIMEOUT_EN
    // Slave never acks: strobe drops after TIMEOUT cycles
    ack_en = 1'b0;
    last_run = 0;
    cs_low();
    send_hdr(1'b1, 1'b0, 7'h12);
    spi_bits(64'h0F0F0F0F, 32, rx);
    cs_high();
    wait_idle("tmo_idle", 1000);
    @(negedge clk);
    check_eq("tmo_len", last_run, 255);
    check_eq("tmo_err", err_o, 1'b1);
    ack_en = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
